wb_sram_bridge: RTL and testbench
=================================

# wb_sram_bridge

Wishbone classic slave that turns 32-bit bus cycles into correctly timed port-0 accesses on the 32x512 dual-port OpenRAM macro, and captures read data from it. Sits between the Caravel user-project Wishbone bus and one `sky130_sram_2kbyte_1rw1r_32x512_8` instance. It is the initiator side of the macro's port-0 protocol: it drives the macro's registered inputs, waits out the negedge read/write, then returns data and ack. Port 1 is parked idle.

## Interface
- BASE_ADDR, 32'h3000_0000, byte base address of the SRAM window (aligned to 2 KiB).
- ADDR_WIDTH, 9, SRAM word-address width.
- wb_clk_i  in  1  clock; also forwarded to both macro clocks.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge, registered.
- wbs_dat_o  out  32  read data, registered.
- sram_clk0  out  1  = wb_clk_i.
- sram_csb0  out  1  active-low chip select, registered.
- sram_web0  out  1  active-low write enable, registered.
- sram_wmask0  out  4  byte write mask, registered.
- sram_addr0  out  ADDR_WIDTH  word address, registered.
- sram_din0  out  32  write data, registered.
- sram_dout0  in  32  macro read data.
- sram_clk1  out  1  = wb_clk_i.
- sram_csb1  out  1  constant 1.
- sram_addr1  out  ADDR_WIDTH  constant 0.

## Operation
- Request = wbs_cyc_i & wbs_stb_i & !wbs_ack_o, sampled in IDLE.
- Hit = wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]; word address = wbs_adr_i[ADDR_WIDTH+1:2]; wbs_adr_i[1:0] ignored.
- FSM states: IDLE, ISSUE, WAIT, ACK.
  - IDLE: on request & hit → ISSUE, registering sram_csb0=0, sram_web0=~wbs_we_i, sram_addr0, sram_din0=wbs_dat_i, sram_wmask0 = wbs_we_i ? wbs_sel_i : 4'b0000. On request & miss → ACK with wbs_dat_o=0, no SRAM access. Else stay.
  - ISSUE: macro latches inputs at the end of this cycle; sram_csb0 returns to 1, sram_web0 to 1, sram_wmask0 to 0 → WAIT.
  - WAIT: macro performs write/read on negedge inside this cycle. At the end of the cycle, capture wbs_dat_o = sram_dout0 for reads (hold previous value for writes), set wbs_ack_o = wbs_cyc_i → ACK.
  - ACK: wbs_ack_o high for exactly this one cycle → IDLE; ack clears at the end of the cycle.
- Write with wbs_sel_i=0: access still issued, memory unchanged, ack returned.
- Abort: wbs_cyc_i dropped in ISSUE/WAIT → SRAM access completes (cannot be cancelled), FSM still passes ACK, but wbs_ack_o stays 0.
- sram_addr0/sram_din0 hold their last value outside ISSUE; only csb0/web0/wmask0 gate activity.

## Timing
- Reset (async assert, sync deassert by the clock edge): state=IDLE, wbs_ack_o=0, wbs_dat_o=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
- Reset mid-transaction: outputs forced to reset values immediately. A write already latched by the macro may still complete. No ack is issued.
- Hit latency: request in cycle 0 → sram_csb0 low in cycle 1 → ack high in cycle 3 (3 cycles). Earliest next request is accepted in cycle 4.
- Miss latency: ack high in cycle 1.
- sram_csb0 is low for exactly one cycle per hit access. There are never back-to-back asserts; minimum gap is 3 cycles.
- wbs_dat_o is stable from the ack cycle until the next read capture.

## Test plan
- Reset: assert wb_rst_i mid-WAIT → all outputs at reset values in the same cycle, no ack; after release, IDLE accepts the next request.
- Write then read: write 0xDEADBEEF, sel=4'hF, to 0x3000_0010 → sram_addr0=4, wmask0=4'hF, ack in cycle 3. Read the same address → wbs_dat_o=0xDEADBEEF with ack in cycle 3.
- Byte mask: start from 0xDEADBEEF, write 0x11223344 with sel=4'b0101 → readback 0xDE22BE44.
- Boundaries: write/read address 0x3000_07FC (word 511) and 0x3000_0000 (word 0) → distinct data retained; no aliasing.
- Miss: read 0x3000_0800 → ack in cycle 1, wbs_dat_o=0, sram_csb0 never low. Write to a miss → memory contents unchanged.
- Abort: drop wbs_cyc_i in ISSUE during a write → no ack; FSM returns to IDLE in cycle 4; a subsequent read shows the written data.

Source files
------------

// File: rtl/wb_sram_bridge.sv
// -----------------------------------------------------------------------------
// wb_sram_bridge
//
// Wishbone classic slave that maps a 2 KiB window of the bus onto port 0 of a
// 32x512 1rw1r OpenRAM macro (sky130_sram_2kbyte_1rw1r_32x512_8). The macro
// registers its inputs on the rising edge and performs the array access on the
// following falling edge, so the bridge presents a one-cycle registered command
// (ISSUE), waits one cycle for the array access (WAIT), captures read data at
// the end of that cycle, and then acknowledges for exactly one cycle (ACK).
// Addresses outside the window are acknowledged immediately with zero data and
// never touch the macro. Port 1 of the macro is parked idle.
//
// Parameters
//   BASE_ADDR   byte base address of the SRAM window (2 KiB aligned)
//   ADDR_WIDTH  SRAM word-address width
//
// Ports
//   wb_clk_i      bus clock, also forwarded to both macro clocks
//   wb_rst_i      asynchronous active-high reset
//   wbs_cyc_i     bus cycle valid
//   wbs_stb_i     strobe
//   wbs_we_i      1 = write
//   wbs_sel_i     byte lane selects
//   wbs_adr_i     byte address
//   wbs_dat_i     write data
//   wbs_ack_o     single-cycle registered acknowledge
//   wbs_dat_o     registered read data
//   sram_clk0     macro port-0 clock (= wb_clk_i)
//   sram_csb0     active-low chip select, registered
//   sram_web0     active-low write enable, registered
//   sram_wmask0   byte write mask, registered
//   sram_addr0    word address, registered
//   sram_din0     write data, registered
//   sram_dout0    macro port-0 read data
//   sram_clk1     macro port-1 clock (= wb_clk_i)
//   sram_csb1     port-1 chip select, tied inactive
//   sram_addr1    port-1 address, tied to zero
// -----------------------------------------------------------------------------
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 9
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  sram_clk0,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [31:0]           sram_din0,
  input  logic [31:0]           sram_dout0,
  output logic                  sram_clk1,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1
);

  // Lowest address bit that belongs to the window tag (above word address).
  localparam int TAG_LSB = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic                    csb_q, csb_d;
  logic                    web_q, web_d;
  logic [3:0]              wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             din_q, din_d;
  // Remembers whether the access in flight is a read. web_q has already
  // returned high by the time the read data must be captured in WAIT.
  logic                    rd_q, rd_d;

  logic                    req;
  logic                    hit;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    unused_adr_bits;

  // A new request is only taken while no ack is being presented, so a master
  // that holds stb through the ack cycle is not serviced twice.
  assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign hit       = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign word_addr = wbs_adr_i[TAG_LSB-1:2];

  // Byte offset within the word has no meaning for a 32-bit port.
  assign unused_adr_bits = ^wbs_adr_i[1:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = hit ? ST_ISSUE : ST_ACK;
        end
      end
      // The macro cannot cancel a latched command, so ISSUE and WAIT always
      // run to completion even if the master abandons the cycle.
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of all registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // Command strobes idle by default; address/data and read data hold.
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = 4'b0000;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_d    = rd_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            csb_d   = 1'b0;
            web_d   = ~wbs_we_i;
            wmask_d = wbs_we_i ? wbs_sel_i : 4'b0000;
            addr_d  = word_addr;
            din_d   = wbs_dat_i;
            rd_d    = ~wbs_we_i;
          end else begin
            // Out-of-window access: immediate ack with zero data.
            ack_d = 1'b1;
            dat_d = 32'h0000_0000;
          end
        end
      end
      ST_WAIT: begin
        // The array access happened on the falling edge of this cycle, so
        // sram_dout0 is valid at the closing rising edge.
        if (rd_q) begin
          dat_d = sram_dout0;
        end
        // An aborted cycle (cyc dropped) still walks through ACK but the
        // acknowledge itself is suppressed.
        ack_d = wbs_cyc_i;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'h0000_0000;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= 4'b0000;
      addr_q  <= '0;
      din_q   <= 32'h0000_0000;
      rd_q    <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Port wiring
  // ---------------------------------------------------------------------------
  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;

  assign sram_clk0   = wb_clk_i;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

  // Port 1 (read-only) is unused and held deselected.
  assign sram_clk1   = wb_clk_i;
  assign sram_csb1   = 1'b1;
  assign sram_addr1  = '0;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for wb_sram_bridge. Includes a behavioural model of the OpenRAM
// macro's port 0 (inputs registered on the rising edge, access on the falling
// edge) and a transaction-level reference of the bus-visible behaviour.
// -----------------------------------------------------------------------------
module tb_wb_sram_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          AW   = 9;
  localparam int          WIN  = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, dati;
  logic          ack;
  logic [31:0]   dato;
  logic          sram_clk0, sram_clk1;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [3:0]    sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [31:0]   sram_din0;
  logic [31:0]   sram_dout0;

  always #5 clk = ~clk;

  wb_sram_bridge #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dati),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dato),
    .sram_clk0  (sram_clk0),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .sram_clk1  (sram_clk1),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1)
  );

  // ---------------------------------------------------------------------------
  // Macro model (port 0)
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [512];
  logic          m_csb = 1'b1;
  logic          m_web = 1'b1;
  logic [3:0]    m_wmask;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_din;

  always @(posedge sram_clk0) begin
    m_csb   <= sram_csb0;
    m_web   <= sram_web0;
    m_wmask <= sram_wmask0;
    m_addr  <= sram_addr0;
    m_din   <= sram_din0;
  end

  always @(negedge sram_clk0) begin
    if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < 4; b++) begin
          if (m_wmask[b]) mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
        end
      end else begin
        sram_dout0 <= mem[m_addr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: word array, written flags, last bus read value
  // ---------------------------------------------------------------------------
  logic [31:0] ref_mem [512];
  bit          ref_valid [512];
  logic [31:0] last_dat;

  int n_total = 0;
  int n_pass  = 0;
  int n_txn   = 0;

  function automatic bit ref_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < WIN);
  endfunction

  function automatic int ref_word(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r = (r & ~(32'hFF << (8*b))) | (nw & (32'hFF << (8*b)));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Bus driver: one classic cycle, cycle 0 = first cycle the request is seen
  // ---------------------------------------------------------------------------
  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s,
                         output logic [31:0] rdata, output int ack_cyc,
                         output int csb_cnt, output int csb_first,
                         output logic iss_web, output logic [3:0] iss_wmask,
                         output logic [AW-1:0] iss_addr, output logic [31:0] iss_din,
                         output logic ack_after, output logic [31:0] dat_after);
    ack_cyc = -1; csb_cnt = 0; csb_first = -1; rdata = 'x;
    iss_web = 'x; iss_wmask = 'x; iss_addr = 'x; iss_din = 'x;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dati = d; sel = s;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!sram_csb0) begin
        if (csb_cnt == 0) begin
          csb_first = c; iss_web = sram_web0; iss_wmask = sram_wmask0;
          iss_addr = sram_addr0; iss_din = sram_din0;
        end
        csb_cnt++;
      end
      if (ack) begin
        ack_cyc = c; rdata = dato;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    ack_after = ack; dat_after = dato;
    if (!sram_csb0) csb_cnt++;
  endtask

  // Runs one transaction and checks it against the reference model.
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] got_dat,
                         output int got_ack);
    bit          h;
    int          wd;
    logic [31:0] exp_dat;
    bit          dat_known;
    int          csb_cnt, csb_first;
    logic        iss_web, ack_after;
    logic [3:0]  iss_wmask;
    logic [AW-1:0] iss_addr;
    logic [31:0] iss_din, dat_after;

    h  = ref_hit(a);
    wd = h ? ref_word(a) : 0;
    dat_known = 1'b1;
    if (!h)      exp_dat = 32'h0;
    else if (w)  exp_dat = last_dat;
    else begin
      exp_dat   = ref_mem[wd];
      dat_known = ref_valid[wd];
    end

    wb_xfer(w, a, d, s, got_dat, got_ack, csb_cnt, csb_first,
            iss_web, iss_wmask, iss_addr, iss_din, ack_after, dat_after);
    n_txn++;
    $display("txn %0d %s adr=%h dat=%h sel=%h hit=%0d -> ack_cyc=%0d dat_o=%h",
             n_txn, w ? "WR" : "RD", a, d, s, h, got_ack, got_dat);

    chk("ack_cycle", got_ack, h ? 3 : 1);
    chk("ack_single", {31'b0, ack_after}, 32'h0);
    chk("csb_count", csb_cnt, h ? 1 : 0);
    if (dat_known) begin
      chk("dat_o", got_dat, exp_dat);
      chk("dat_hold", dat_after, exp_dat);
    end
    if (h) begin
      chk("csb_cycle", csb_first, 1);
      chk("iss_web", {31'b0, iss_web}, {31'b0, ~w});
      chk("iss_wmask", {28'b0, iss_wmask}, w ? {28'b0, s} : 32'h0);
      chk("iss_addr", {23'b0, iss_addr}, wd);
      chk("iss_din", iss_din, d);
    end

    if (h && w) begin
      ref_mem[wd]   = merge(ref_valid[wd] ? ref_mem[wd] : 32'h0, d, s);
      ref_valid[wd] = ref_valid[wd] || (s == 4'hF);
      if (s != 4'hF && !ref_valid[wd]) ref_valid[wd] = 1'b0;
    end
    last_dat = exp_dat;
    if (!dat_known) last_dat = got_dat;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_dat;
    int          exp_ack;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] gd;
    int          ga;
    int          ack_seen;

    tbl[0]  = '{1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 3};
    tbl[1]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 3};
    tbl[2]  = '{1'b1, 32'h3000_0010, 32'h1122_3344, 4'h5, 32'hDEAD_BEEF, 3};
    tbl[3]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 32'hDE22_BE44, 3};
    tbl[4]  = '{1'b1, 32'h3000_07FC, 32'hA5A5_0001, 4'hF, 32'hDE22_BE44, 3};
    tbl[5]  = '{1'b1, 32'h3000_0000, 32'h5A5A_0002, 4'hF, 32'hDE22_BE44, 3};
    tbl[6]  = '{1'b0, 32'h3000_07FC, 32'h0,         4'hF, 32'hA5A5_0001, 3};
    tbl[7]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 32'h5A5A_0002, 3};
    tbl[8]  = '{1'b0, 32'h3000_0800, 32'h0,         4'hF, 32'h0000_0000, 1};
    tbl[9]  = '{1'b1, 32'h3000_0800, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1};
    tbl[10] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 32'h5A5A_0002, 3};
    tbl[11] = '{1'b1, 32'h3000_0014, 32'hCAFE_F00D, 4'hF, 32'h5A5A_0002, 3};
    tbl[12] = '{1'b1, 32'h3000_0014, 32'h1234_5678, 4'h0, 32'h5A5A_0002, 3};
    tbl[13] = '{1'b0, 32'h3000_0014, 32'h0,         4'hF, 32'hCAFE_F00D, 3};
    tbl[14] = '{1'b0, 32'h2000_0010, 32'h0,         4'hF, 32'h0000_0000, 1};
    tbl[15] = '{1'b0, 32'h3000_0013, 32'h0,         4'hF, 32'hDE22_BE44, 3};
    tbl[16] = '{1'b0, 32'h3000_07FF, 32'h0,         4'hF, 32'hA5A5_0001, 3};

    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = 32'h0; ref_valid[i] = 1'b0;
    end
    last_dat = 32'h0;
    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dati = 0;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   {31'b0, ack},          32'h0);
    chk("rst_dat",   dato,                  32'h0);
    chk("rst_csb0",  {31'b0, sram_csb0},    32'h1);
    chk("rst_web0",  {31'b0, sram_web0},    32'h1);
    chk("rst_wmask", {28'b0, sram_wmask0},  32'h0);
    chk("rst_addr0", {23'b0, sram_addr0},   32'h0);
    chk("rst_din0",  sram_din0,             32'h0);
    chk("rst_csb1",  {31'b0, sram_csb1},    32'h1);
    chk("rst_addr1", {23'b0, sram_addr1},   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven directed vectors
    for (int i = 0; i < 17; i++) begin
      run_txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, gd, ga);
      chk($sformatf("tbl%0d_dat", i), gd, tbl[i].exp_dat);
      chk($sformatf("tbl%0d_ack", i), ga, tbl[i].exp_ack);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rd;
      logic [3:0]  rs;
      bit          rw;
      int          wd;
      if ($urandom_range(0, 99) < 10) begin
        ra = $urandom;
        if (ref_hit(ra)) ra = ra ^ 32'h8000_0000;
      end else begin
        wd = $urandom_range(0, 511);
        ra = BASE + 32'(wd * 4) + 32'($urandom_range(0, 3));
      end
      rw = 1'($urandom_range(0, 1));
      rs = 4'($urandom_range(0, 15));
      rd = $urandom;
      if (!rw && ref_hit(ra) && !ref_valid[ref_word(ra)]) begin
        rw = 1'b1; rs = 4'hF;
      end
      run_txn(rw, ra, rd, rs, gd, ga);
    end

    // Abort: cyc dropped during ISSUE of a write
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0030; dati = 32'h0BAD_F00D; sel = 4'hF;
    @(negedge clk);
    chk("abort_c0_ack", {31'b0, ack}, 32'h0);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("abort_issue_csb", {31'b0, sram_csb0}, 32'h0);
    ack_seen = 0;
    for (int c = 2; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (ack) ack_seen++;
      if (!sram_csb0) ack_seen++;
    end
    chk("abort_no_ack", ack_seen, 0);
    ref_mem[12] = 32'h0BAD_F00D; ref_valid[12] = 1'b1;
    // Next request lands in cycle 4 and must see the normal 3-cycle latency.
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, gd, ga);
    chk("abort_readback", gd, 32'h0BAD_F00D);

    // Reset asserted in the middle of WAIT
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0020; dati = 32'h7777_7777; sel = 4'hF;
    @(posedge clk); #1;
    chk("rstw_issue_csb", {31'b0, sram_csb0}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rstw_ack",   {31'b0, ack},         32'h0);
    chk("rstw_dat",   dato,                 32'h0);
    chk("rstw_csb0",  {31'b0, sram_csb0},   32'h1);
    chk("rstw_web0",  {31'b0, sram_web0},   32'h1);
    chk("rstw_wmask", {28'b0, sram_wmask0}, 32'h0);
    chk("rstw_addr0", {23'b0, sram_addr0},  32'h0);
    chk("rstw_din0",  sram_din0,            32'h0);
    cyc = 0; stb = 0; we = 0;
    ack_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ack) ack_seen++;
    end
    chk("rstw_no_ack", ack_seen, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_valid[8] = 1'b0;
    last_dat = 32'h0;
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, gd, ga);
    chk("rstw_after_ack", ga, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
